axi_refill_line_assembler: RTL and testbench



---
 rtl/axi_refill_line_assembler.sv | 102 ++++++++++
 tb/tb_axi_refill_line_assembler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_refill_line_assembler.sv
// axi_refill_line_assembler: packs AXI R beats into one cache line with ID capture,
// sticky error tracking and RLAST consistency, then hands the line to the cache.
module axi_refill_line_assembler #(
    parameter int LineWidth = 128,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 r_valid_i,
    output logic                 r_ready_o,
    input  logic [DataWidth-1:0] r_data_i,
    input  logic [IdWidth-1:0]   r_id_i,
    input  logic [1:0]           r_resp_i,
    input  logic                 r_last_i,
    output logic                 line_valid_o,
    input  logic                 line_ready_i,
    output logic [LineWidth-1:0] line_data_o,
    output logic [IdWidth-1:0]   line_id_o,
    output logic                 line_err_o
);
    localparam int Beats = LineWidth / DataWidth;
    localparam int CntW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

    if (LineWidth < DataWidth || LineWidth % DataWidth != 0) begin : g_bad_width
        $error("LineWidth must be a positive multiple of DataWidth");
    end

    typedef enum logic [1:0] {COLLECT, FULL, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 drain_q, drain_d;
    logic [LineWidth-1:0] line_q, line_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic                 err_q, err_d;
    logic                 beat_hs, line_hs, first, at_end, beat_err;
    logic                 resp_unused;

    assign resp_unused  = r_resp_i[0];
    assign r_ready_o    = state_q != FULL;
    assign line_valid_o = state_q == FULL;
    assign line_data_o  = line_q;
    assign line_id_o    = id_q;
    assign line_err_o   = err_q;
    assign beat_hs      = r_valid_i & r_ready_o;
    assign line_hs      = line_valid_o & line_ready_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        line_d   = line_q;
        id_d     = id_q;
        err_d    = err_q;
        first    = cnt_q == '0;
        at_end   = cnt_q == LastCnt;
        beat_err = r_resp_i[1] | (!first & (r_id_i != id_q));
        case (state_q)
            COLLECT: if (beat_hs) begin
                // a new line starts from zero so early-last slots read back as zero
                line_d = first ? '0 : line_q;
                line_d[cnt_q*DataWidth +: DataWidth] = r_data_i;
                id_d   = first ? r_id_i : id_q;
                err_d  = (first ? 1'b0 : err_q) | beat_err | (r_last_i ^ at_end);
                cnt_d  = cnt_q + 1'b1;
                if (r_last_i | at_end) begin
                    state_d = FULL;
                    drain_d = ~r_last_i;
                end
            end
            FULL: if (line_hs) begin
                cnt_d   = '0;
                state_d = drain_q ? DRAIN : COLLECT;
            end
            DRAIN: if (beat_hs & r_last_i) begin
                state_d = COLLECT;
                drain_d = 1'b0;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            line_q  <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            line_q  <= line_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_axi_refill_line_assembler.sv
// tb_axi_refill_line_assembler: directed and random bursts checked against a beat-list model.
module tb_axi_refill_line_assembler;
    localparam int LW = 128;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int BEATS = LW / DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r_valid = 1'b0;
    logic          r_ready;
    logic [DW-1:0] r_data = '0;
    logic [IW-1:0] r_id = '0;
    logic [1:0]    r_resp = '0;
    logic          r_last = 1'b0;
    logic          line_valid;
    logic          line_ready = 1'b1;
    logic [LW-1:0] line_data;
    logic [IW-1:0] line_id;
    logic          line_err;

    int checks = 0;
    int failures = 0;
    bit rand_lr = 1'b0;

    axi_refill_line_assembler #(.LineWidth(LW), .DataWidth(DW), .IdWidth(IW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_id_i(r_id),
        .r_resp_i(r_resp), .r_last_i(r_last),
        .line_valid_o(line_valid), .line_ready_i(line_ready),
        .line_data_o(line_data), .line_id_o(line_id), .line_err_o(line_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Model: a list of beats for the line being built, plus the line owed to the cache.
    logic [DW-1:0] mb [BEATS];
    int            mn = 0;
    logic [IW-1:0] mid = '0;
    bit            merr = 0, mfull = 0, mdrain = 0, edrain = 0, eerr = 0;
    logic [LW-1:0] eline = '0;
    logic [IW-1:0] eid = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mn = 0; mfull = 0; mdrain = 0; edrain = 0;
        end else begin
            chk("valid", LW'(line_valid), LW'(mfull));
            chk("ready", LW'(r_ready), LW'(!mfull));
            if (mfull) begin
                chk("line_data", line_data, eline);
                chk("line_id", LW'(line_id), LW'(eid));
                chk("line_err", LW'(line_err), LW'(eerr));
                if (line_ready) begin
                    mfull = 0;
                    mdrain = edrain;
                end
            end else if (r_valid) begin
                if (mdrain) begin
                    if (r_last) mdrain = 0;
                end else begin
                    if (mn == 0) begin
                        for (int k = 0; k < BEATS; k++) mb[k] = '0;
                        mid = r_id;
                        merr = r_resp[1];
                    end else merr = merr | r_resp[1] | (r_id != mid);
                    mb[mn] = r_data;
                    mn++;
                    if (r_last || mn == BEATS) begin
                        for (int k = 0; k < BEATS; k++) eline[k*DW +: DW] = mb[k];
                        eid = mid;
                        eerr = merr | (r_last != (mn == BEATS));
                        edrain = !r_last;
                        mfull = 1;
                        mn = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_lr) line_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [IW-1:0] id, input logic [1:0] rs, input bit last);
        bit hs = 0;
        r_valid = 1'b1; r_data = d; r_id = id; r_resp = rs; r_last = last;
        for (int i = 0; i < 60 && !hs; i++) begin
            @(negedge clk);
            hs = r_ready;
            step();
        end
        if (!hs) begin
            failures++;
            $display("FAIL beat_timeout got=no_handshake expected=handshake");
        end
        r_valid = 1'b0; r_last = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ready", LW'(r_ready), LW'(1));
        chk("rst_valid", LW'(line_valid), LW'(0));
        chk("rst_data", line_data, '0);
        chk("rst_id", LW'(line_id), LW'(0));
        rst_n = 1'b1;
        step();

        send(64'h1111_2222_3333_4444, 4'd3, 2'b00, 0);
        send(64'h5555_6666_7777_8888, 4'd3, 2'b00, 1);
        @(negedge clk);
        chk("norm_valid", LW'(line_valid), LW'(1));
        chk("norm_ready", LW'(r_ready), LW'(0));
        chk("norm_data", line_data, 128'h5555_6666_7777_8888_1111_2222_3333_4444);
        chk("norm_id", LW'(line_id), LW'(3));
        chk("norm_err", LW'(line_err), LW'(0));
        step();
        @(negedge clk);
        chk("norm_ready_back", LW'(r_ready), LW'(1));
        step();

        send(64'hAAAA, 4'd5, 2'b00, 1);
        @(negedge clk);
        chk("early_data", line_data, {64'h0, 64'hAAAA});
        chk("early_err", LW'(line_err), LW'(1));
        step();

        send(64'h10, 4'd2, 2'b00, 0);
        send(64'h20, 4'd2, 2'b10, 1);
        @(negedge clk);
        chk("resp_data", line_data, {64'h20, 64'h10});
        chk("resp_err", LW'(line_err), LW'(1));
        step();
        send(64'h30, 4'd2, 2'b01, 0);
        send(64'h40, 4'd2, 2'b00, 1);
        @(negedge clk);
        chk("clean_err", LW'(line_err), LW'(0));
        step();

        send(64'hA0, 4'd7, 2'b00, 0);
        send(64'hA1, 4'd7, 2'b00, 0);
        @(negedge clk);
        chk("miss_data", line_data, {64'hA1, 64'hA0});
        chk("miss_err", LW'(line_err), LW'(1));
        step();
        send(64'hA2, 4'd7, 2'b00, 0);
        send(64'hA3, 4'd7, 2'b00, 1);
        send(64'hB0, 4'd8, 2'b00, 0);
        send(64'hB1, 4'd8, 2'b00, 1);
        @(negedge clk);
        chk("after_drain_data", line_data, {64'hB1, 64'hB0});
        chk("after_drain_err", LW'(line_err), LW'(0));
        step();

        send(64'hC0, 4'd1, 2'b00, 0);
        send(64'hC1, 4'd2, 2'b00, 1);
        @(negedge clk);
        chk("idmis_id", LW'(line_id), LW'(1));
        chk("idmis_err", LW'(line_err), LW'(1));
        step();

        line_ready = 1'b0;
        send(64'hD0, 4'd4, 2'b00, 0);
        send(64'hD1, 4'd4, 2'b00, 1);
        fork
            begin
                repeat (5) @(posedge clk);
                #1 line_ready = 1'b1;
            end
        join_none
        send(64'hE0, 4'd6, 2'b00, 0);
        send(64'hE1, 4'd6, 2'b00, 1);
        @(negedge clk);
        chk("bp_data", line_data, {64'hE1, 64'hE0});
        chk("bp_id", LW'(line_id), LW'(6));
        step();

        rand_lr = 1'b1;
        for (int b = 0; b < 120; b++) begin
            int len;
            logic [IW-1:0] bid;
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : BEATS;
            bid = IW'($urandom);
            for (int k = 0; k < len; k++) begin
                logic [IW-1:0] id;
                logic [1:0] rs;
                id = ($urandom_range(0, 9) == 0) ? IW'($urandom) : bid;
                rs = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) step();
                send({$urandom, $urandom}, id, rs, k == len - 1);
            end
        end
        rand_lr = 1'b0;
        line_ready = 1'b1;
        repeat (3) step();

        send(64'hF0, 4'd9, 2'b00, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ready", LW'(r_ready), LW'(1));
        chk("async_valid", LW'(line_valid), LW'(0));
        chk("async_data", line_data, '0);
        chk("async_id", LW'(line_id), LW'(0));
        chk("async_err", LW'(line_err), LW'(0));
        repeat (2) step();
        rst_n = 1'b1;
        step();
        send(64'h77, 4'd2, 2'b00, 0);
        send(64'h88, 4'd2, 2'b00, 1);
        @(negedge clk);
        chk("post_rst_data", line_data, {64'h88, 64'h77});
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
